// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data width, the hardwired-zero register index and
// the writeback source encoding used by the decoder, wb_mux and forwarding.
package cpu_pkg;

    localparam int XLEN = 32;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam logic [2:0] WB_ALU   = 3'd0;
    localparam logic [2:0] WB_MEM   = 3'd1;
    localparam logic [2:0] WB_PC4   = 3'd2;
    localparam logic [2:0] WB_PCIMM = 3'd3;
    localparam logic [2:0] WB_CP0   = 3'd4;

    // Select flags are not guaranteed one-hot, so collapse them by priority.
    function automatic logic [2:0] wb_src_encode(
        input logic mem_sel,
        input logic pc4_sel,
        input logic pcimm_sel,
        input logic cp0_sel
    );
        if (cp0_sel)        return WB_CP0;
        else if (pcimm_sel) return WB_PCIMM;
        else if (pc4_sel)   return WB_PC4;
        else if (mem_sel)   return WB_MEM;
        else                return WB_ALU;
    endfunction

endpackage

// File: rtl/wb_mux.sv
// Writeback source select: priority CP0 > PC+imm > PC+4 > load data > ALU.
module wb_mux
    import cpu_pkg::*;
#(
    parameter int XLEN_P = XLEN
) (
    input  logic [XLEN_P-1:0] AluOut,
    input  logic [XLEN_P-1:0] Mout,
    input  logic [XLEN_P-1:0] pc4,
    input  logic [XLEN_P-1:0] PCImm,
    input  logic [XLEN_P-1:0] CP0out,
    input  logic              memtoReg,
    input  logic              pc4toReg,
    input  logic              pcImmtoReg,
    input  logic              CP0toReg,
    output logic [XLEN_P-1:0] wbData
);

    logic [2:0] w_src;

    assign w_src = wb_src_encode(memtoReg, pc4toReg, pcImmtoReg, CP0toReg);

    // NOTE: assign a default before the case so no path leaves wbData unassigned (no latch).
    always_comb begin
        wbData = AluOut;
        case (w_src)
            WB_MEM:   wbData = Mout;
            WB_PC4:   wbData = pc4;
            WB_PCIMM: wbData = PCImm;
            WB_CP0:   wbData = CP0out;
            default:  wbData = AluOut;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// MEM/WB consumer: integer register file with write-before-read bypass,
// a one-cycle delayed writeback copy for EX forwarding, and a write counter.
module wb_regfile
    import cpu_pkg::*;
#(
    parameter int XLEN_P = XLEN,
    parameter int NREG   = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN_P-1:0] AluOut,
    input  logic [XLEN_P-1:0] Mout,
    input  logic [XLEN_P-1:0] pc4,
    input  logic [XLEN_P-1:0] PCImm,
    input  logic [XLEN_P-1:0] CP0out,
    input  logic              regesterW,
    input  logic              memtoReg,
    input  logic              pc4toReg,
    input  logic              pcImmtoReg,
    input  logic              CP0toReg,
    input  logic [4:0]        Rd,
    input  logic [4:0]        Rs1,
    input  logic [4:0]        Rs2,
    output logic [XLEN_P-1:0] Rs1Data,
    output logic [XLEN_P-1:0] Rs2Data,
    output logic [XLEN_P-1:0] wbData,
    output logic              wbEn,
    output logic [4:0]        wbRd,
    output logic [XLEN_P-1:0] wbDatao,
    output logic              wbEno,
    output logic [4:0]        wbRdo,
    output logic [CNT_W-1:0]  wrCount
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [XLEN_P-1:0] r_regs [NREG];
    logic [XLEN_P-1:0] r_wb_data;
    logic              r_wb_en;
    logic [4:0]        r_wb_rd;
    logic [CNT_W-1:0]  r_wr_count;

    logic [XLEN_P-1:0] w_wb_data;
    logic              w_wb_en;

    wb_mux #(.XLEN_P(XLEN_P)) u_wb_mux (
        .AluOut     (AluOut),
        .Mout       (Mout),
        .pc4        (pc4),
        .PCImm      (PCImm),
        .CP0out     (CP0out),
        .memtoReg   (memtoReg),
        .pc4toReg   (pc4toReg),
        .pcImmtoReg (pcImmtoReg),
        .CP0toReg   (CP0toReg),
        .wbData     (w_wb_data)
    );

    assign w_wb_en = regesterW && (Rd != REG_ZERO);

    // NOTE: the array is flop-based and reset on purpose so no read ever sees X;
    // this rules out mapping it onto a RAM macro.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb_en) begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            r_regs[Rd] <= w_wb_data;
        end
    end

    // Delayed copy updates every cycle, even for non-writing instructions.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wb_data  <= '0;
            r_wb_en    <= 1'b0;
            r_wb_rd    <= '0;
            r_wr_count <= '0;
        end else begin
            r_wb_data <= w_wb_data;
            r_wb_en   <= w_wb_en;
            r_wb_rd   <= Rd;
            if (w_wb_en) begin
                r_wr_count <= r_wr_count + CNT_ONE;
            end
        end
    end

    always_comb begin
        Rs1Data = r_regs[Rs1];
        if (Rs1 == REG_ZERO) begin
            Rs1Data = '0;
        end else if (w_wb_en && (Rs1 == Rd)) begin
            Rs1Data = w_wb_data;
        end
    end

    always_comb begin
        Rs2Data = r_regs[Rs2];
        if (Rs2 == REG_ZERO) begin
            Rs2Data = '0;
        end else if (w_wb_en && (Rs2 == Rd)) begin
            Rs2Data = w_wb_data;
        end
    end

    assign wbData  = w_wb_data;
    assign wbEn    = w_wb_en;
    assign wbRd    = Rd;
    assign wbDatao = r_wb_data;
    assign wbEno   = r_wb_en;
    assign wbRdo   = r_wb_rd;
    assign wrCount = r_wr_count;

endmodule
